cpu_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the 8-bit, four-register (R0–R3) teaching CPU.
- Fetches each 16-bit instruction as two bytes from the 8-bit memory bus and decodes it.
- Drives the RX/RY register-select, ALU, flag, register-file write, PC and memory strobes that sequence the datapath.
- Sits between the instruction register / flag register and the rest of the datapath. It owns no data, only control.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/cpu_ctrl_fsm_if.sv | 23 ++
 rtl/cpu_ctrl_fsm_decode.sv | 34 +++
 rtl/cpu_ctrl_fsm.sv | 165 ++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the teaching-CPU control path: opcodes, ALU encodings,
// IR field positions, the sequencer state type and the EX control word.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS_B = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_AND    = 3'd3;
    localparam logic [2:0] ALU_OR     = 3'd4;

    localparam int IR_OP_MSB = 15;
    localparam int IR_OP_LSB = 12;
    localparam int IR_RX_MSB = 11;
    localparam int IR_RX_LSB = 10;
    localparam int IR_RY_MSB = 9;
    localparam int IR_RY_LSB = 8;

    typedef enum logic [2:0] {
        IF_HI = 3'd0,
        IF_LO = 3'd1,
        DEC   = 3'd2,
        EX    = 3'd3,
        MEM   = 3'd4,
        HALT  = 3'd5
    } ctrl_state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       b_sel;
        logic       rf_we;
        logic       flag_ld;
        logic       pc_ld;
        logic       illegal;
        logic       go_mem;
        logic       go_halt;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_IDLE = '{alu_op: 3'd0, default: 1'b0};

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Memory-bus handshake between the control sequencer and the memory port.
interface cpu_ctrl_fsm_if;

    logic mem_rd;
    logic mem_wr;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_rd,
        output mem_wr,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        input  addr_sel,
        output mem_ready
    );

endinterface

// File: rtl/cpu_ctrl_fsm_decode.sv
// Combinational map from opcode and flags to the control word used in EX.
module ctrl_decode
    import cpu_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] opcode,
    input  logic           z_in,
    input  logic           c_in,
    output ex_ctrl_t       ctrl
);

    // Opcode decode; undefined opcodes behave as NOP apart from the illegal flag
    always_comb begin
        ctrl = EX_IDLE;
        case (opcode)
            OP_NOP: ctrl = EX_IDLE;
            OP_ADD: begin ctrl.alu_op = ALU_ADD; ctrl.rf_we = 1'b1; ctrl.flag_ld = 1'b1; end
            OP_SUB: begin ctrl.alu_op = ALU_SUB; ctrl.rf_we = 1'b1; ctrl.flag_ld = 1'b1; end
            OP_AND: begin ctrl.alu_op = ALU_AND; ctrl.rf_we = 1'b1; ctrl.flag_ld = 1'b1; end
            OP_OR:  begin ctrl.alu_op = ALU_OR;  ctrl.rf_we = 1'b1; ctrl.flag_ld = 1'b1; end
            OP_MOV: begin ctrl.alu_op = ALU_PASS_B; ctrl.rf_we = 1'b1; end
            OP_LDI: begin ctrl.alu_op = ALU_PASS_B; ctrl.b_sel = 1'b1; ctrl.rf_we = 1'b1; end
            OP_LD:  ctrl.go_mem = 1'b1;
            OP_ST:  ctrl.go_mem = 1'b1;
            OP_JMP: ctrl.pc_ld = 1'b1;
            OP_JZ:  ctrl.pc_ld = z_in;
            OP_JC:  ctrl.pc_ld = c_in;
            OP_HLT: ctrl.go_halt = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: two-byte fetch, decode, execute and the
// optional memory phase, with register-select latching and bus handshake gating.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int OPW = 4,
    parameter int RSW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [15:0]    ir,
    input  logic           z_in,
    input  logic           c_in,
    cpu_ctrl_fsm_if.master mem,
    output logic           ir_hi_ld,
    output logic           ir_lo_ld,
    output logic           pc_inc,
    output logic           pc_ld,
    output logic [RSW-1:0] rx_sel,
    output logic [RSW-1:0] ry_sel,
    output logic [2:0]     alu_op,
    output logic           b_sel,
    output logic           flag_ld,
    output logic           rf_we,
    output logic           halted,
    output logic           illegal
);

    ctrl_state_t    state_q, state_d;
    logic [RSW-1:0] rx_sel_q, rx_sel_d;
    logic [RSW-1:0] ry_sel_q, ry_sel_d;
    logic           mem_rd_s, mem_wr_s, addr_sel_s;
    logic [OPW-1:0] opcode_s;
    logic           is_ld_s;
    ex_ctrl_t       ex_ctrl_s;

    // The address byte goes straight from IR to the datapath, not through here
    logic [7:0]     ir_addr_unused;

    assign ir_addr_unused = ir[7:0];
    assign opcode_s       = ir[IR_OP_MSB:IR_OP_LSB];
    assign is_ld_s        = (opcode_s == OP_LD);

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode (opcode_s),
        .z_in   (z_in),
        .c_in   (c_in),
        .ctrl   (ex_ctrl_s)
    );

    assign mem.mem_rd   = mem_rd_s;
    assign mem.mem_wr   = mem_wr_s;
    assign mem.addr_sel = addr_sel_s;

    // State and select registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IF_HI;
            rx_sel_q <= '0;
            ry_sel_q <= '0;
        end else begin
            state_q  <= state_d;
            rx_sel_q <= rx_sel_d;
            ry_sel_q <= ry_sel_d;
        end
    end

    // Next state and strobes; reset silences every output in the same cycle
    always_comb begin
        state_d    = state_q;
        rx_sel_d   = rx_sel_q;
        ry_sel_d   = ry_sel_q;
        mem_rd_s   = 1'b0;
        mem_wr_s   = 1'b0;
        addr_sel_s = 1'b0;
        ir_hi_ld   = 1'b0;
        ir_lo_ld   = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        rx_sel     = '0;
        ry_sel     = '0;
        alu_op     = ALU_PASS_B;
        b_sel      = 1'b0;
        flag_ld    = 1'b0;
        rf_we      = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        if (rst) begin
            state_d  = IF_HI;
            rx_sel_d = '0;
            ry_sel_d = '0;
        end else begin
            rx_sel = rx_sel_q;
            ry_sel = ry_sel_q;
            case (state_q)
                IF_HI: begin
                    mem_rd_s = 1'b1;
                    if (mem.mem_ready) begin
                        ir_hi_ld = 1'b1;
                        pc_inc   = 1'b1;
                        state_d  = IF_LO;
                    end else begin
                        state_d  = IF_HI;
                    end
                end
                IF_LO: begin
                    mem_rd_s = 1'b1;
                    if (mem.mem_ready) begin
                        ir_lo_ld = 1'b1;
                        pc_inc   = 1'b1;
                        state_d  = DEC;
                    end else begin
                        state_d  = IF_LO;
                    end
                end
                DEC: begin
                    rx_sel_d = ir[IR_RX_MSB:IR_RX_LSB];
                    ry_sel_d = ir[IR_RY_MSB:IR_RY_LSB];
                    state_d  = EX;
                end
                EX: begin
                    alu_op  = ex_ctrl_s.alu_op;
                    b_sel   = ex_ctrl_s.b_sel;
                    rf_we   = ex_ctrl_s.rf_we;
                    flag_ld = ex_ctrl_s.flag_ld;
                    pc_ld   = ex_ctrl_s.pc_ld;
                    illegal = ex_ctrl_s.illegal;
                    if (ex_ctrl_s.go_halt) begin
                        state_d = HALT;
                    end else if (ex_ctrl_s.go_mem) begin
                        state_d = MEM;
                    end else begin
                        state_d = IF_HI;
                    end
                end
                MEM: begin
                    // Anything reaching MEM that is not a load is a store
                    addr_sel_s = 1'b1;
                    mem_rd_s   = is_ld_s;
                    mem_wr_s   = ~is_ld_s;
                    if (mem.mem_ready) begin
                        if (is_ld_s) begin
                            alu_op = ALU_PASS_B;
                            b_sel  = 1'b1;
                            rf_we  = 1'b1;
                        end else begin
                            rf_we  = 1'b0;
                        end
                        state_d = IF_HI;
                    end else begin
                        state_d = MEM;
                    end
                end
                HALT: begin
                    halted  = 1'b1;
                    state_d = HALT;
                end
                default: begin
                    state_d = IF_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: every cycle's full output word is compared
// against a hand-built expectation.
module tb_cpu_ctrl_fsm;
    import cpu_pkg::*;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       addr_sel;
        logic       ir_hi_ld;
        logic       ir_lo_ld;
        logic       pc_inc;
        logic       pc_ld;
        logic [1:0] rx;
        logic [1:0] ry;
        logic [2:0] alu;
        logic       b_sel;
        logic       flag_ld;
        logic       rf_we;
        logic       halted;
        logic       illegal;
    } ov_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        z_in, c_in;
    logic        ir_hi_ld, ir_lo_ld, pc_inc, pc_ld;
    logic [1:0]  rx_sel, ry_sel;
    logic [2:0]  alu_op;
    logic        b_sel, flag_ld, rf_we, halted, illegal;
    logic [1:0]  cur_rx, cur_ry;
    int          total = 0;
    int          bad   = 0;
    ov_t         e;

    cpu_ctrl_fsm_if bus ();

    cpu_ctrl_fsm #(.OPW(4), .RSW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ir       (ir),
        .z_in     (z_in),
        .c_in     (c_in),
        .mem      (bus.master),
        .ir_hi_ld (ir_hi_ld),
        .ir_lo_ld (ir_lo_ld),
        .pc_inc   (pc_inc),
        .pc_ld    (pc_ld),
        .rx_sel   (rx_sel),
        .ry_sel   (ry_sel),
        .alu_op   (alu_op),
        .b_sel    (b_sel),
        .flag_ld  (flag_ld),
        .rf_we    (rf_we),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic ov_t base();
        ov_t o;
        o    = '0;
        o.rx = cur_rx;
        o.ry = cur_ry;
        return o;
    endfunction

    // One clock: drive mem_ready, check mid-cycle, advance past the next edge
    task automatic step(input string tag, input logic rdy, input ov_t exp_v);
        ov_t o;
        bus.mem_ready = rdy;
        #1;
        o = {bus.mem_rd, bus.mem_wr, bus.addr_sel, ir_hi_ld, ir_lo_ld, pc_inc, pc_ld,
             rx_sel, ry_sel, alu_op, b_sel, flag_ld, rf_we, halted, illegal};
        total++;
        assert (o === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, o, exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] w, input int hw, input int lw);
        ov_t x;
        for (int i = 0; i < hw; i++) begin
            x = base(); x.mem_rd = 1'b1;
            step("if_hi_wait", 1'b0, x);
        end
        x = base(); x.mem_rd = 1'b1; x.ir_hi_ld = 1'b1; x.pc_inc = 1'b1;
        step("if_hi", 1'b1, x);
        for (int i = 0; i < lw; i++) begin
            x = base(); x.mem_rd = 1'b1;
            step("if_lo_wait", 1'b0, x);
        end
        x = base(); x.mem_rd = 1'b1; x.ir_lo_ld = 1'b1; x.pc_inc = 1'b1;
        step("if_lo", 1'b1, x);
        ir = w;
        x = base();
        step("dec", 1'b1, x);
        cur_rx = w[11:10];
        cur_ry = w[9:8];
    endtask

    initial begin
        rst = 1'b1; ir = 16'h0000; z_in = 1'b0; c_in = 1'b0;
        bus.mem_ready = 1'b0; cur_rx = 2'd0; cur_ry = 2'd0;
        @(posedge clk);
        #1;
        step("rst", 1'b1, base());
        rst = 1'b0;

        fetch(16'h1600, 0, 0);
        e = base(); e.alu = 3'd1; e.rf_we = 1'b1; e.flag_ld = 1'b1;
        step("add_ex", 1'b1, e);
        fetch(16'h2500, 1, 0);
        e = base(); e.alu = 3'd2; e.rf_we = 1'b1; e.flag_ld = 1'b1;
        step("sub_ex", 1'b1, e);
        fetch(16'h3000, 0, 0);
        e = base(); e.alu = 3'd3; e.rf_we = 1'b1; e.flag_ld = 1'b1;
        step("and_ex", 1'b1, e);
        fetch(16'h4B00, 0, 0);
        e = base(); e.alu = 3'd4; e.rf_we = 1'b1; e.flag_ld = 1'b1;
        step("or_ex", 1'b1, e);
        fetch(16'h5700, 0, 0);
        e = base(); e.rf_we = 1'b1;
        step("mov_ex", 1'b1, e);
        fetch(16'h6E55, 0, 0);
        e = base(); e.rf_we = 1'b1; e.b_sel = 1'b1;
        step("ldi_ex", 1'b1, e);

        fetch(16'h7C40, 0, 1);
        step("ld_ex", 1'b1, base());
        e = base(); e.mem_rd = 1'b1; e.addr_sel = 1'b1;
        step("ld_mem_wait1", 1'b0, e);
        step("ld_mem_wait2", 1'b0, e);
        e.b_sel = 1'b1; e.rf_we = 1'b1;
        step("ld_mem_done", 1'b1, e);

        z_in = 1'b1;
        fetch(16'hA020, 0, 0);
        e = base(); e.pc_ld = 1'b1;
        step("jz_taken", 1'b1, e);
        z_in = 1'b0;
        fetch(16'hA020, 0, 0);
        step("jz_not_taken", 1'b1, base());
        c_in = 1'b1;
        fetch(16'hB030, 0, 0);
        e = base(); e.pc_ld = 1'b1;
        step("jc_taken", 1'b1, e);
        c_in = 1'b0;
        fetch(16'hB030, 0, 0);
        step("jc_not_taken", 1'b1, base());
        fetch(16'h9040, 0, 0);
        e = base(); e.pc_ld = 1'b1;
        step("jmp_ex", 1'b1, e);

        fetch(16'h8810, 0, 0);
        step("st_ex", 1'b1, base());
        e = base(); e.mem_wr = 1'b1; e.addr_sel = 1'b1;
        step("st_mem_wait", 1'b0, e);
        step("st_mem_done", 1'b1, e);

        fetch(16'h0000, 0, 0);
        step("nop_ex", 1'b1, base());
        fetch(16'hD000, 0, 0);
        e = base(); e.illegal = 1'b1;
        step("illegal_ex", 1'b1, e);
        fetch(16'h1600, 0, 0);
        e = base(); e.alu = 3'd1; e.rf_we = 1'b1; e.flag_ld = 1'b1;
        step("after_illegal", 1'b1, e);

        z_in = 1'b1; c_in = 1'b1;
        fetch(16'hF000, 0, 0);
        step("hlt_ex", 1'b1, base());
        e = base(); e.halted = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step("halt_hold", 1'b1, e);
        end
        rst = 1'b1;
        step("rst_in_halt", 1'b1, '0);
        rst = 1'b0;
        cur_rx = 2'd0; cur_ry = 2'd0;

        e = base(); e.mem_rd = 1'b1; e.ir_hi_ld = 1'b1; e.pc_inc = 1'b1;
        step("post_halt_if_hi", 1'b1, e);
        e = base(); e.mem_rd = 1'b1;
        step("if_lo_wait_pre_rst", 1'b0, e);
        rst = 1'b1;
        step("rst_mid_fetch", 1'b1, '0);
        rst = 1'b0;
        e = base(); e.mem_rd = 1'b1;
        step("rst_release_if_hi", 1'b0, e);
        e = base(); e.mem_rd = 1'b1; e.ir_hi_ld = 1'b1; e.pc_inc = 1'b1;
        step("rst_release_load", 1'b1, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
